div_arbiter: RTL and testbench

//  Shares one 2-stage pipelined 64/32 unsigned divider core (div32p2) between two requesters.

---
 rtl/div_arbiter.sv | 167 ++++++++++++++++
 tb/tb_div_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// Round-robin front end sharing one 2-stage pipelined 64/32 unsigned divider between two
// requesters, with a credit-managed response FIFO. Define DIVARB_ERRCHK_EN for error checking.
module div_arbiter #(
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_x,
  input  logic [31:0] req0_d,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_x,
  input  logic [31:0] req1_d,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_q,
  output logic [31:0] rsp_r,
  output logic        rsp_err,
  output logic        busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic        id;
`ifdef DIVARB_ERRCHK_EN
    logic        err;
`endif
    logic [63:0] x;
    logic [31:0] d;
  } op_t;

  typedef struct packed {
    logic        id;
`ifdef DIVARB_ERRCHK_EN
    logic        err;
`endif
    logic [31:0] q;
    logic [31:0] r;
  } rsp_t;

  logic [LATENCY-1:0] vpipe_q;
  logic               rr_last_q;
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      inflight;
  logic [CW:0]        used;
  logic               credit_ok;
  logic               grant0, grant1, issue;
  logic               push, pop;

  op_t                op_q [LATENCY-1];
  op_t                issue_op;
  op_t                div_op;
  rsp_t               res_d, res_q;
  rsp_t               fifo_mem [FIFO_DEPTH];
  rsp_t               head;
  logic [31:0]        d_safe;

  // NOTE: combinational blocks use blocking '=' with a default first (no latches);
  // every clocked block below uses non-blocking '<='.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + CW'(vpipe_q[i]);
  end

  // A pop in this cycle frees its slot only from the next cycle on.
  assign used      = {1'b0, inflight} + {1'b0, count_q};
  assign credit_ok = used < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rstn && credit_ok) begin
      if (req0_valid && req1_valid) begin
        grant0 = rr_last_q;
        grant1 = !rr_last_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign issue      = grant0 | grant1;

  // Core input mux: holds the last issued operands when nothing is granted.
  always_comb begin
    issue_op = op_q[0];
    if (issue) begin
      issue_op.id = grant1;
      issue_op.x  = grant1 ? req1_x : req0_x;
      issue_op.d  = grant1 ? req1_d : req0_d;
`ifdef DIVARB_ERRCHK_EN
      issue_op.err = (issue_op.d == '0) || (issue_op.x[63:32] >= issue_op.d);
`endif
    end
  end

  // Final core stage: 64/32 divide, quotient truncated to 32 bits.
  always_comb begin
    div_op   = op_q[LATENCY-2];
    d_safe   = (div_op.d == '0) ? 32'd1 : div_op.d;
    res_d.id = div_op.id;
    res_d.q  = 32'(div_op.x / {32'd0, d_safe});
    res_d.r  = 32'(div_op.x % {32'd0, d_safe});
`ifdef DIVARB_ERRCHK_EN
    res_d.err = div_op.err;
    if (div_op.err) begin
      res_d.q = '1;
      res_d.r = div_op.x[63:32];
    end
`endif
  end

  // NOTE: datapath and FIFO storage carry no reset; the valid bits and the FIFO
  // count qualify them, so resetting the wide registers would only cost area.
  always_ff @(posedge clk) begin
    op_q[0] <= issue_op;
    for (int i = 1; i < LATENCY-1; i++) op_q[i] <= op_q[i-1];
    res_q <= res_d;
    if (push) fifo_mem[wr_ptr_q] <= res_q;
  end

  assign push = vpipe_q[LATENCY-1];
  assign pop  = rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vpipe_q   <= '0;
      rr_last_q <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      vpipe_q <= {vpipe_q[LATENCY-2:0], issue};
      if (issue) rr_last_q <= grant1;
      if (push)  wr_ptr_q  <= wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_q  <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head      = fifo_mem[rd_ptr_q];
  assign rsp_valid = (count_q != '0);
  assign rsp_id    = rsp_valid & head.id;
  assign rsp_q     = head.q;
  assign rsp_r     = head.r;
`ifdef DIVARB_ERRCHK_EN
  assign rsp_err   = rsp_valid & head.err;
`else
  assign rsp_err   = 1'b0;
`endif
  assign busy      = (|vpipe_q) | rsp_valid;

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter: driver predicts grants and expected results from a
// plain-arithmetic model; a separate monitor pops and compares on every response handshake.
module tb_div_arbiter;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [63:0] req0_x, req1_x;
  logic [31:0] req0_d, req1_d;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [31:0] rsp_q, rsp_r;

  div_arbiter #(.LATENCY(2), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_d(req0_d),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_d(req1_d),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        err;
    logic [31:0] q;
    logic [31:0] r;
    int          gcyc;
    bit          exact;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, failures = 0;
  int          cyc = 0;
  int          issued = 0, popped = 0, rr_m = 1, dut_g = 0, n_iss = 0;
  bit          log_g = 0, exact_next = 0, rdy = 0;
  int          gq[$];
  bit          vs[2];
  logic [63:0] xs[2];
  logic [31:0] ds[2];

  always @(posedge clk) cyc++;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(int id, logic [63:0] x, logic [31:0] d, int g, bit exact);
    exp_t        e;
    logic [63:0] qf;
    e.id = id; e.gcyc = g; e.exact = exact; e.err = 1'b0;
`ifdef DIVARB_ERRCHK_EN
    if (d == 0 || x[63:32] >= d) begin
      e.err = 1'b1; e.q = 32'hFFFF_FFFF; e.r = x[63:32];
      return e;
    end
`endif
    qf  = x / {32'd0, d};
    e.q = qf[31:0];
    e.r = 32'(x % {32'd0, d});
    return e;
  endfunction

  task automatic rnd_op(int i);
    logic [31:0] d, hi;
    d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : 32'($urandom);
`ifdef DIVARB_ERRCHK_EN
    if ($urandom_range(0, 15) == 0) d = 32'd0;
`else
    if (d == 32'd0) d = 32'd1;
`endif
    hi = ($urandom_range(0, 3) == 0 || d == 32'd0) ? 32'($urandom)
                                                   : 32'($urandom_range(d - 32'd1, 0));
    vs[i] = 1'b1;
    xs[i] = {hi, 32'($urandom)};
    ds[i] = d;
  endtask

  // One clock: drive at the falling edge, predict and check the grant just after.
  task automatic cycle();
    int w;
    @(negedge clk);
    req0_valid = vs[0]; req0_x = xs[0]; req0_d = ds[0];
    req1_valid = vs[1]; req1_x = xs[1]; req1_d = ds[1];
    rsp_ready  = rdy;
    #1;
    w = -1;
    if (issued - popped < DEPTH) begin
      if (vs[0] && vs[1]) w = (rr_m == 0) ? 1 : 0;
      else if (vs[0])     w = 0;
      else if (vs[1])     w = 1;
    end
    check("req0_ready", req0_ready, w == 0);
    check("req1_ready", req1_ready, w == 1);
    dut_g += int'(req0_ready) + int'(req1_ready);
    if (log_g && (req0_ready || req1_ready)) gq.push_back(req1_ready ? 1 : 0);
    if (w >= 0) begin
      sb.push_back(model(w, xs[w], ds[w], cyc, exact_next));
      issued++; n_iss++;
      rr_m  = w;
      vs[w] = 1'b0;
    end
  endtask

  task automatic issue_one(int id, logic [63:0] x, logic [31:0] d);
    int n = 0;
    vs[id] = 1'b1; xs[id] = x; ds[id] = d;
    while (vs[id] && n < 50) begin cycle(); n++; end
    check("issue_accepted", vs[id], 1'b0);
    vs[id] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    vs[0] = 1'b0; vs[1] = 1'b0; rdy = 1'b1;
    while ((sb.size() != 0 || busy) && n < 200) begin cycle(); n++; end
    check("drain_done", (sb.size() == 0 && !busy), 1'b1);
  endtask

  task automatic stream(int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 2; i++) if (!vs[i]) rnd_op(i);
      cycle();
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rstn && rsp_valid) begin
        if (sb.size() == 0) check("unexpected_rsp", 1'b1, 1'b0);
        else if (rsp_ready) begin
          e = sb.pop_front();
          check("rsp_id",  rsp_id,  e.id[0]);
          check("rsp_q",   rsp_q,   e.q);
          check("rsp_r",   rsp_r,   e.r);
          check("rsp_err", rsp_err, e.err);
          if (e.exact) check("latency", cyc - e.gcyc, 3);
          popped++;
        end
      end
    end
  end

  initial begin : main
    int start, n;
    vs[0] = 1'b0; vs[1] = 1'b0; xs[0] = '0; xs[1] = '0; ds[0] = 32'd1; ds[1] = 32'd1;
    rstn = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_x = 64'd5; req1_x = 64'd6; req0_d = 32'd1; req1_d = 32'd1;
    #2;
    check("rst_req0_ready", req0_ready, 1'b0);
    check("rst_req1_ready", req1_ready, 1'b0);
    check("rst_rsp_valid",  rsp_valid,  1'b0);
    check("rst_rsp_id",     rsp_id,     1'b0);
    check("rst_rsp_err",    rsp_err,    1'b0);
    check("rst_busy",       busy,       1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Both streaming from reset: grants alternate 0,1,0,1.
    rdy = 1'b1; log_g = 1'b1; gq.delete();
    stream(8);
    log_g = 1'b0;
    check("alt_count", gq.size() >= 4, 1'b1);
    for (int k = 0; k < 4 && k < gq.size(); k++) check("alt_grant", gq[k], k % 2);
    drain();

    // Single op on an idle unit, exact latency.
    exact_next = 1'b1;
    issue_one(0, 64'd100, 32'd7);
    exact_next = 1'b0;
    drain();

    // Consumer stalled: exactly DEPTH grants, then resume.
    rdy = 1'b0; start = dut_g;
    stream(10);
    check("stall_grants", dut_g - start, DEPTH);
    rdy = 1'b1;
    start = dut_g;
    stream(10);
    check("resume_grants", dut_g - start > 0, 1'b1);
    drain();

    // Boundary operands.
    issue_one(1, 64'h0_FFFF_FFFF, 32'd1);
    issue_one(0, 64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF);
`ifdef DIVARB_ERRCHK_EN
    issue_one(0, 64'h1234, 32'd0);
    issue_one(1, 64'h1_0000_0000, 32'd1);
`endif
    drain();

    // Reset with two results in flight and two buffered.
    rdy = 1'b0;
    stream(4);
    @(negedge clk);
    check("mid_busy",      busy,      1'b1);
    check("mid_rsp_valid", rsp_valid, 1'b1);
    rstn = 1'b0;
    vs[0] = 1'b0; vs[1] = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    #1;
    check("rst2_busy",       busy,       1'b0);
    check("rst2_rsp_valid",  rsp_valid,  1'b0);
    check("rst2_req0_ready", req0_ready, 1'b0);
    sb.delete(); issued = 0; popped = 0; rr_m = 1;
    req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    rdy = 1'b1;
    repeat (10) cycle();
    check("post_rst_rsp_valid", rsp_valid, 1'b0);
    check("post_rst_busy",      busy,      1'b0);

    // Random traffic against the model.
    start = n_iss; n = 0;
    while (n_iss - start < 10000 && n < 60000) begin
      for (int i = 0; i < 2; i++) if (!vs[i] && $urandom_range(0, 2) != 0) rnd_op(i);
      rdy = ($urandom_range(0, 3) != 0);
      cycle();
      n++;
    end
    check("random_ops_done", n_iss - start >= 10000, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
